// File: rtl/frame_serializer.sv
// frame_serializer: queues 32-bit frames and sends each one as four bytes, byte0 first.
// Latency: byte0 appears on the lane one edge after the push into an empty queue; the
//   expected avg/diff pulse on the edge after byte3. Backpressure: in_ready = !full.
// Ports: clk/rst (async, active-high); in_data/in_valid/in_ready push side;
//   ser_out/ser_valid/frame_start serial lane; exp_avg/exp_diff/exp_valid expected result.
module frame_serializer #(
  parameter int          DEPTH     = 2,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  ser_out,
  output logic        ser_valid,
  output logic        frame_start,
  output logic [7:0]  exp_avg,
  output logic [7:0]  exp_diff,
  output logic        exp_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SEND} tx_state_e;

  // FIFO storage and pointers (one extra MSB distinguishes full from empty)
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        full, empty, push, pop;
  logic [31:0] head;

  // tx state
  tx_state_e   state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  ser_out_q, ser_out_d;
  logic        ser_valid_q, ser_valid_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  exp_avg_q, exp_avg_d;
  logic [7:0]  exp_diff_q, exp_diff_d;
  logic        exp_valid_q, exp_valid_d;
  logic        last_byte;

  // expected-result arithmetic on the latched frame
  logic [9:0]  sum_w;
  logic [7:0]  avg_w;
  logic [7:0]  diff_w;

  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = in_valid && !full;
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign sum_w  = 10'(shadow_q[7:0]) + 10'(shadow_q[15:8])
                + 10'(shadow_q[23:16]) + 10'(shadow_q[31:24]);
  assign avg_w  = 8'(sum_w >> 2);
  assign diff_w = (avg_w >= shadow_q[31:24]) ? (avg_w - shadow_q[31:24])
                                             : (shadow_q[31:24] - avg_w);

  // FIFO next state
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = in_data;
      wptr_d = wptr_q + (AW+1)'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end
  end

  // tx FSM next state / outputs. phase_q is the index of the next byte to load,
  // so SEND with phase_q==0 means byte3 is currently on the lane.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    shadow_d      = shadow_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = 1'b0;
    exp_avg_d     = exp_avg_q;
    exp_diff_d    = exp_diff_q;
    exp_valid_d   = 1'b0;
    pop           = 1'b0;
    last_byte     = (state_q == SEND) && (phase_q == 2'd0);

    if (last_byte) begin
      exp_avg_d   = avg_w;
      exp_diff_d  = diff_w;
      exp_valid_d = 1'b1;
    end

    if ((state_q == IDLE) || last_byte) begin
      if (!empty) begin
        // pop here frees the slot; the frame lives on in the shadow register
        pop           = 1'b1;
        shadow_d      = head;
        ser_out_d     = head[7:0];
        ser_valid_d   = 1'b1;
        frame_start_d = 1'b1;
        phase_d       = 2'd1;
        state_d       = SEND;
      end else begin
        ser_out_d   = IDLE_BYTE;
        ser_valid_d = 1'b0;
        phase_d     = 2'd0;
        state_d     = IDLE;
      end
    end else begin
      ser_out_d   = shadow_q[{phase_q, 3'b000} +: 8];
      ser_valid_d = 1'b1;
      phase_d     = phase_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q        <= '0;
      rptr_q        <= '0;
      state_q       <= IDLE;
      phase_q       <= 2'd0;
      shadow_q      <= '0;
      ser_out_q     <= IDLE_BYTE;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      exp_avg_q     <= '0;
      exp_diff_q    <= '0;
      exp_valid_q   <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      state_q       <= state_d;
      phase_q       <= phase_d;
      shadow_q      <= shadow_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      exp_avg_q     <= exp_avg_d;
      exp_diff_q    <= exp_diff_d;
      exp_valid_q   <= exp_valid_d;
    end
  end

  assign in_ready    = !full;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign exp_avg     = exp_avg_q;
  assign exp_diff    = exp_diff_q;
  assign exp_valid   = exp_valid_q;

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed bench for frame_serializer with hand-computed results.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the source holds in_valid/in_data until in_ready was high before an edge.
module tb_frame_serializer;

  localparam logic [7:0] IDLE_B = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  ser_out;
  logic        ser_valid;
  logic        frame_start;
  logic [7:0]  exp_avg;
  logic [7:0]  exp_diff;
  logic        exp_valid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fr [4];
  logic [7:0]  ea [4];
  logic [7:0]  ed [4];
  logic [31:0] pp [3];

  frame_serializer #(.DEPTH(2), .IDLE_BYTE(IDLE_B)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .exp_avg     (exp_avg),
    .exp_diff    (exp_diff),
    .exp_valid   (exp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_ser_out"}, 32'(ser_out), 32'(IDLE_B));
    chk({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_exp_avg"}, 32'(exp_avg), 32'd0);
    chk({tag, "_exp_diff"}, 32'(exp_diff), 32'd0);
    chk({tag, "_exp_valid"}, 32'(exp_valid), 32'd0);
  endtask

  // push one frame into an idle DUT and follow it to its expected result
  task automatic single(input logic [31:0] d, input logic [7:0] xa, input logic [7:0] xd,
                        input string nm);
    chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("%s_b%0d", nm, k), 32'(ser_out), 32'(d[8*k +: 8]));
      chk($sformatf("%s_fs%0d", nm, k), 32'(frame_start), (k == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s_sv%0d", nm, k), 32'(ser_valid), 32'd1);
      chk($sformatf("%s_ev%0d", nm, k), 32'(exp_valid), 32'd0);
    end
    tick();
    chk({nm, "_exp_valid"}, 32'(exp_valid), 32'd1);
    chk({nm, "_exp_avg"}, 32'(exp_avg), 32'(xa));
    chk({nm, "_exp_diff"}, 32'(exp_diff), 32'(xd));
    chk({nm, "_idle_sv"}, 32'(ser_valid), 32'd0);
    chk({nm, "_idle_out"}, 32'(ser_out), 32'(IDLE_B));
    tick();
    chk({nm, "_ev_pulse"}, 32'(exp_valid), 32'd0);
    chk({nm, "_avg_hold"}, 32'(exp_avg), 32'(xa));
    chk({nm, "_diff_hold"}, 32'(exp_diff), 32'(xd));
  endtask

  initial begin
    fr[0] = 32'h04030201; ea[0] = 8'd2;   ed[0] = 8'd2;
    fr[1] = 32'h08080808; ea[1] = 8'd8;   ed[1] = 8'd0;
    fr[2] = 32'h10203040; ea[2] = 8'd40;  ed[2] = 8'd24;
    fr[3] = 32'h00FF00FF; ea[3] = 8'd127; ed[3] = 8'd127;
    pp[0] = 32'h13121110;
    pp[1] = 32'h23222120;
    pp[2] = 32'h33323130;

    // reset
    rst = 1'b1;
    tick(); tick(); tick();
    chk_reset_vals("rst0");
    rst = 1'b0;

    single(32'h04030201, 8'd2,   8'd2,  "f01");
    single(32'hFFFFFFFF, 8'd255, 8'd0,  "fff");
    single(32'h80000000, 8'd32,  8'd96, "f80");

    // back-to-back stream with in_valid held high
    fork
      begin : source
        int  i;
        bit  saw_full;
        logic rdy;
        i = 0;
        saw_full = 1'b0;
        for (int t = 0; t < 40 && i < 4; t++) begin
          in_valid = 1'b1;
          in_data  = fr[i];
          rdy      = in_ready;
          if (!rdy) saw_full = 1'b1;
          tick();
          if (rdy) i++;
        end
        in_valid = 1'b0;
        chk("b2b_all_pushed", 32'(i), 32'd4);
        chk("b2b_in_ready_dropped", 32'(saw_full), 32'd1);
      end
      begin : monitor
        int pulses;
        pulses = 0;
        tick();
        for (int c = 0; c < 16; c++) begin
          tick();
          chk($sformatf("b2b_sv%0d", c), 32'(ser_valid), 32'd1);
          chk($sformatf("b2b_b%0d", c), 32'(ser_out), 32'(fr[c/4][8*(c%4) +: 8]));
          chk($sformatf("b2b_fs%0d", c), 32'(frame_start), (c % 4 == 0) ? 32'd1 : 32'd0);
          chk($sformatf("b2b_ev%0d", c), 32'(exp_valid),
              (c % 4 == 0 && c > 0) ? 32'd1 : 32'd0);
          if (exp_valid) begin
            pulses++;
            if (c >= 4) begin
              chk($sformatf("b2b_avg%0d", c), 32'(exp_avg), 32'(ea[c/4 - 1]));
              chk($sformatf("b2b_diff%0d", c), 32'(exp_diff), 32'(ed[c/4 - 1]));
            end
          end
        end
        tick();
        if (exp_valid) pulses++;
        chk("b2b_ev_last", 32'(exp_valid), 32'd1);
        chk("b2b_avg_last", 32'(exp_avg), 32'(ea[3]));
        chk("b2b_diff_last", 32'(exp_diff), 32'(ed[3]));
        chk("b2b_sv_end", 32'(ser_valid), 32'd0);
        chk("b2b_pulses", 32'(pulses), 32'd4);
      end
    join
    tick();
    chk("b2b_ev_clear", 32'(exp_valid), 32'd0);

    // push and pop on the same edge at the byte3 boundary
    in_data  = pp[0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c <= 12) begin
        chk($sformatf("pp_b%0d", c), 32'(ser_out), 32'(pp[(c-1)/4][8*((c-1)%4) +: 8]));
        chk($sformatf("pp_fs%0d", c), 32'(frame_start), ((c-1) % 4 == 0) ? 32'd1 : 32'd0);
        chk($sformatf("pp_sv%0d", c), 32'(ser_valid), 32'd1);
      end
      if (c == 1) begin
        in_data  = pp[1];
        in_valid = 1'b1;
      end
      if (c == 2) in_valid = 1'b0;
      if (c == 4) begin
        chk("pp_rdy_before", 32'(in_ready), 32'd1);
        in_data  = pp[2];
        in_valid = 1'b1;
      end
      if (c == 5) begin
        in_valid = 1'b0;
        chk("pp_rdy_after", 32'(in_ready), 32'd1);
        chk("pp_avg1", 32'(exp_avg), 32'd17);
        chk("pp_diff1", 32'(exp_diff), 32'd2);
      end
      if (c == 9) chk("pp_avg2", 32'(exp_avg), 32'd33);
      if (c == 13) begin
        chk("pp_sv_end", 32'(ser_valid), 32'd0);
        chk("pp_out_end", 32'(ser_out), 32'(IDLE_B));
        chk("pp_ev3", 32'(exp_valid), 32'd1);
        chk("pp_avg3", 32'(exp_avg), 32'd49);
        chk("pp_diff3", 32'(exp_diff), 32'd2);
      end
    end
    tick();
    chk("pp_no_extra", 32'(ser_valid), 32'd0);

    // reset while byte2 is on the lane, with another frame queued
    in_data  = 32'h44332211;
    in_valid = 1'b1;
    tick();
    in_data  = 32'h55555555;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_b2", 32'(ser_out), 32'h33);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    tick();
    tick();
    chk("mid_rst_ev", 32'(exp_valid), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post_rst_sv%0d", c), 32'(ser_valid), 32'd0);
      chk($sformatf("post_rst_ev%0d", c), 32'(exp_valid), 32'd0);
    end
    single(32'h01010101, 8'd1, 8'd0, "f0101");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_serializer.md
# frame_serializer

Transmit-side companion to the serial averaging receiver. Accepts 32-bit sample frames over a valid/ready handshake, buffers them in a small FIFO, and emits each frame as four consecutive 8-bit samples on a byte-wide serial lane with a frame marker. For every frame it also produces the expected receiver result (4-sample average and |average − last sample|), so the bench or the downstream checker can compare it against the receiver output.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥ 2.
- IDLE_BYTE, 8'h00: value driven on ser_out when no frame is in flight.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  32  frame payload; byte0 = in_data[7:0] is sent first, byte3 = in_data[31:24] is sent last.
- in_valid  in  1  in_data valid.
- in_ready  out  1  FIFO can accept; equals !full, registered state only.
- ser_out  out  8  serial sample lane (registered).
- ser_valid  out  1  ser_out carries a frame byte.
- frame_start  out  1  high with byte0 of each frame.
- exp_avg  out  8  expected average of the last completed frame.
- exp_diff  out  8  expected |exp_avg − byte3| of the last completed frame.
- exp_valid  out  1  one-cycle pulse when exp_avg/exp_diff update.

## Operation
- Reset values: in_ready=1, ser_out=IDLE_BYTE, ser_valid=0, frame_start=0, exp_avg=0, exp_diff=0, exp_valid=0; FIFO empty; phase=0; tx state IDLE.
- Push: on an edge with in_valid && in_ready. If in_valid is high while in_ready is low, the data is ignored and the source must hold it.
- The FIFO uses read and write pointers of log2(DEPTH)+1 bits. full = MSBs differ and LSBs equal. empty = pointers equal.
- The tx FSM has two states, IDLE and SEND, plus a 2-bit phase counter.
  - IDLE: if the FIFO is non-empty, pop the head at this edge. Load ser_out=byte0, ser_valid=1, frame_start=1, phase=1, and go to SEND. Otherwise ser_out=IDLE_BYTE and ser_valid=0.
  - SEND, phase 1..3: ser_out = byte[phase] of the latched frame, frame_start=0, and phase increments.
  - SEND, phase 3 (byte3 loaded): on the next edge, if the FIFO is non-empty, pop and load byte0 of the next frame. This gives back-to-back frames with no gap. Otherwise go to IDLE.
- The popped frame is latched in a 32-bit shadow register, so the FIFO slot frees at pop time.
- Push and pop in the same edge are allowed. Occupancy stays unchanged. in_ready is computed from pre-edge full, so a full FIFO refuses a push even when a pop occurs on that edge.
- Expected-result arithmetic, computed from the shadow frame:
  - sum = b0+b1+b2+b3 in 10 bits; no overflow, max 1020.
  - avg = sum[9:2].
  - diff = avg ≥ b3 ? avg − b3 : b3 − avg, 8-bit unsigned.
  - exp_avg and exp_diff are registered on the edge after byte3 is on ser_out. exp_valid pulses for exactly that one cycle. Values hold until the next frame completes.
- Reset asserted mid-frame: everything returns to reset values immediately, the partial frame is dropped, FIFO contents are lost, and no exp_valid is produced for the dropped frame.

## Timing
- Frame accepted on edge E with the FIFO empty and tx IDLE:
  - byte0 is visible after edge E+1, with frame_start=1.
  - byte k is visible after edge E+1+k.
  - exp_valid is high after edge E+5.
- Steady state: one byte per cycle; ser_valid stays high continuously while the FIFO keeps up; frame_start is high every 4th cycle.
- Sustained throughput: one frame per 4 cycles. With DEPTH=2, the source sees in_ready=0 at most while 2 frames are queued behind the one in flight.
- exp_valid for frame N coincides with the cycle carrying byte0 of frame N+1 when frames are back-to-back.
- Deasserting rst takes effect at the next rising edge. The earliest push is on the first edge after deassertion.

## Test plan
- Single frame 0x04030201 after reset:
  - ser_out 1,2,3,4 on consecutive cycles, with frame_start only on 1.
  - Then exp_avg=2, exp_diff=2 with exp_valid a 1-cycle pulse, followed by ser_valid=0 and ser_out=IDLE_BYTE.
- Frame 0xFFFFFFFF: exp_avg=255, exp_diff=0 (sum 1020, no truncation error).
- Frame 0x80000000: bytes 0,0,0,128; exp_avg=32, exp_diff=96 (b3 > avg branch).
- in_valid held high with frames A, B, C, D pushed every time in_ready is high:
  - in_ready drops after the FIFO fills.
  - Frames are emitted back-to-back in order, with no idle cycles and ser_valid continuously high across 16 cycles.
  - exp_valid fires 4 times, 4 cycles apart.
- Simultaneous push and pop with the FIFO holding one entry at the phase-3 boundary: occupancy stays 1, and no frame is lost or duplicated.
- rst asserted on the cycle carrying byte2:
  - All outputs go to reset values immediately, and no exp_valid follows.
  - After release, a new frame 0x01010101 gives exp_avg=1, exp_diff=0.
